// File: rtl/dac_cal_scheduler_if.sv
// Bus bundle between the VGA pixel source and the DAC calibration scheduler.
// The master drives the video/timing inputs; the slave drives the DAC codes and status.
interface dac_cal_scheduler_if;
  logic [7:0] i_vid_r;
  logic [7:0] i_vid_g;
  logic [7:0] i_vid_b;
  logic       i_hblank;
  logic       i_vblank;
  logic       i_test_en;
  logic [7:0] o_dac_r;
  logic [7:0] o_dac_g;
  logic [7:0] o_dac_b;
  logic       o_cal_busy;
  logic [1:0] o_cal_chan;
  logic       o_cal_step;
  logic       o_cal_done;
  logic       o_cal_abort;

  modport master (
    output i_vid_r, i_vid_g, i_vid_b, i_hblank, i_vblank, i_test_en,
    input  o_dac_r, o_dac_g, o_dac_b, o_cal_busy, o_cal_chan,
    input  o_cal_step, o_cal_done, o_cal_abort
  );

  modport slave (
    input  i_vid_r, i_vid_g, i_vid_b, i_hblank, i_vblank, i_test_en,
    output o_dac_r, o_dac_g, o_dac_b, o_cal_busy, o_cal_chan,
    output o_cal_step, o_cal_done, o_cal_abort
  );
endinterface

// File: rtl/dac_cal_scheduler.sv
// Arbitrates the RGB DAC buses between live video and a per-channel calibration ramp
// that runs inside a single vertical-blanking interval.
module dac_cal_scheduler #(
  parameter int         CAL_LINE    = 2,
  parameter int         STEP_CYCLES = 1,
  parameter logic [7:0] BLACK_LEVEL = 8'h00
) (
  input logic           clk,
  input logic           rst,
  dac_cal_scheduler_if.slave bus
);
  localparam int             LW        = (CAL_LINE < 1) ? 1 : $clog2(CAL_LINE + 1);
  localparam logic [LW-1:0]  LINE_LAST = LW'(CAL_LINE);
  localparam logic [7:0]     HOLD_LAST = 8'(STEP_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RAMP_R = 3'd2;
  localparam logic [2:0] S_RAMP_G = 3'd3;
  localparam logic [2:0] S_RAMP_B = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    r_state;
  logic [7:0]    r_ramp;
  logic [7:0]    r_hold;
  logic [LW-1:0] r_line;
  logic          r_vblank_q;
  logic          r_hblank_q;
  logic [7:0]    r_dac_r;
  logic [7:0]    r_dac_g;
  logic [7:0]    r_dac_b;
  logic          r_busy;
  logic [1:0]    r_chan;
  logic          r_step;
  logic          r_done;
  logic          r_abort;

  logic          w_vrise;
  logic          w_hfall;
  logic          w_blank;
  logic          w_ramping;
  logic          w_abort;
  logic          w_hold_term;
  logic [1:0]    w_chan;
  logic [2:0]    w_next_ramp;

  always_comb begin
    w_vrise     = bus.i_vblank & ~r_vblank_q;
    w_hfall     = ~bus.i_hblank & r_hblank_q;
    w_blank     = bus.i_hblank | bus.i_vblank;
    w_hold_term = (r_hold == HOLD_LAST);
    w_chan      = 2'd0;
    w_next_ramp = S_IDLE;
    case (r_state)
      S_RAMP_R: begin w_chan = 2'd1; w_next_ramp = S_RAMP_G; end
      S_RAMP_G: begin w_chan = 2'd2; w_next_ramp = S_RAMP_B; end
      S_RAMP_B: begin w_chan = 2'd3; w_next_ramp = S_DONE;   end
      default:  begin w_chan = 2'd0; w_next_ramp = S_IDLE;   end
    endcase
    w_ramping = (w_chan != 2'd0);
    w_abort   = ((r_state == S_WAIT) || w_ramping) && (!bus.i_vblank || !bus.i_test_en);
  end

  // Defaults give the normal video path; an abort keeps them so live video wins immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ramp     <= 8'd0;
      r_hold     <= 8'd0;
      r_line     <= '0;
      r_vblank_q <= 1'b0;
      r_hblank_q <= 1'b0;
      r_dac_r    <= BLACK_LEVEL;
      r_dac_g    <= BLACK_LEVEL;
      r_dac_b    <= BLACK_LEVEL;
      r_busy     <= 1'b0;
      r_chan     <= 2'd0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_vblank_q <= bus.i_vblank;
      r_hblank_q <= bus.i_hblank;
      r_busy     <= 1'b0;
      r_chan     <= 2'd0;
      r_step     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_dac_r    <= w_blank ? BLACK_LEVEL : bus.i_vid_r;
      r_dac_g    <= w_blank ? BLACK_LEVEL : bus.i_vid_g;
      r_dac_b    <= w_blank ? BLACK_LEVEL : bus.i_vid_b;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_abort <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_vrise && bus.i_test_en) begin
              r_state <= S_WAIT;
              r_line  <= '0;
            end
          end
          S_WAIT: begin
            r_busy <= 1'b1;
            if (w_hfall) begin
              if (r_line == LINE_LAST) begin
                r_state <= S_RAMP_R;
                r_ramp  <= 8'd0;
                r_hold  <= 8'd0;
              end else begin
                r_line <= r_line + LW'(1);
              end
            end
          end
          S_RAMP_R, S_RAMP_G, S_RAMP_B: begin
            r_busy  <= 1'b1;
            r_chan  <= w_chan;
            r_step  <= (r_hold == 8'd0);
            r_dac_r <= (w_chan == 2'd1) ? r_ramp : BLACK_LEVEL;
            r_dac_g <= (w_chan == 2'd2) ? r_ramp : BLACK_LEVEL;
            r_dac_b <= (w_chan == 2'd3) ? r_ramp : BLACK_LEVEL;
            if (w_hold_term) begin
              r_hold <= 8'd0;
              r_ramp <= r_ramp + 8'd1;
              if (r_ramp == 8'hFF) begin
                r_state <= w_next_ramp;
              end
            end else begin
              r_hold <= r_hold + 8'd1;
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_dac_r     = r_dac_r;
  assign bus.o_dac_g     = r_dac_g;
  assign bus.o_dac_b     = r_dac_b;
  assign bus.o_cal_busy  = r_busy;
  assign bus.o_cal_chan  = r_chan;
  assign bus.o_cal_step  = r_step;
  assign bus.o_cal_done  = r_done;
  assign bus.o_cal_abort = r_abort;
endmodule

// File: tb/tb_dac_cal_scheduler.sv
// Bench for dac_cal_scheduler: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against a ramp-index model of the calibration sequence.
module tb_dac_cal_scheduler;
  localparam int         CAL_LINE = 2;
  localparam int         STEP     = 2;
  localparam logic [7:0] BLACK    = 8'h00;
  localparam int         TOTAL    = 3 * 256 * STEP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dac_cal_scheduler_if bus();

  dac_cal_scheduler #(
    .CAL_LINE   (CAL_LINE),
    .STEP_CYCLES(STEP),
    .BLACK_LEVEL(BLACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a sequence is either waiting for its start line or sitting at ramp index mIdx
  // (0 .. TOTAL-1); channel, code and step pulse all follow from that index arithmetically.
  bit         modelValid = 1'b0;
  bit         mWait, mRamp, mDonePend;
  logic       mVq, mHq;
  int         mLines, mIdx, mCh;
  logic [7:0] mCode;
  logic [7:0] eR, eG, eB;
  logic       eBusy, eStep, eDone, eAbort;
  logic [1:0] eChan;

  always @(posedge clk) begin
    if (rst) begin
      modelValid = 1'b1;
      mWait = 1'b0; mRamp = 1'b0; mDonePend = 1'b0;
      mVq = 1'b0; mHq = 1'b0;
      eR = BLACK; eG = BLACK; eB = BLACK;
      eBusy = 1'b0; eChan = 2'd0; eStep = 1'b0; eDone = 1'b0; eAbort = 1'b0;
    end else begin
      if (bus.i_hblank || bus.i_vblank) begin
        eR = BLACK; eG = BLACK; eB = BLACK;
      end else begin
        eR = bus.i_vid_r; eG = bus.i_vid_g; eB = bus.i_vid_b;
      end
      eBusy = 1'b0; eChan = 2'd0; eStep = 1'b0; eDone = 1'b0; eAbort = 1'b0;
      if (mDonePend) begin
        eDone = 1'b1;
        mDonePend = 1'b0;
      end else if (mWait || mRamp) begin
        if (!bus.i_vblank || !bus.i_test_en) begin
          eAbort = 1'b1;
          mWait = 1'b0;
          mRamp = 1'b0;
        end else if (mWait) begin
          eBusy = 1'b1;
          if (!bus.i_hblank && mHq) begin
            if (mLines == CAL_LINE) begin
              mWait = 1'b0; mRamp = 1'b1; mIdx = 0;
            end else begin
              mLines++;
            end
          end
        end else begin
          mCh   = mIdx / (256 * STEP);
          mCode = 8'((mIdx / STEP) % 256);
          eBusy = 1'b1;
          eChan = 2'(mCh + 1);
          eStep = ((mIdx % STEP) == 0);
          eR = (mCh == 0) ? mCode : BLACK;
          eG = (mCh == 1) ? mCode : BLACK;
          eB = (mCh == 2) ? mCode : BLACK;
          mIdx++;
          if (mIdx == TOTAL) begin
            mRamp = 1'b0;
            mDonePend = 1'b1;
          end
        end
      end else if (bus.i_vblank && !mVq && bus.i_test_en) begin
        mWait = 1'b1;
        mLines = 0;
      end
      mVq = bus.i_vblank;
      mHq = bus.i_hblank;
    end
  end

  always @(posedge clk) begin
    #1;
    if (modelValid) begin
      checks++;
      if ({bus.o_dac_r, bus.o_dac_g, bus.o_dac_b, bus.o_cal_busy, bus.o_cal_chan,
           bus.o_cal_step, bus.o_cal_done, bus.o_cal_abort} !==
          {eR, eG, eB, eBusy, eChan, eStep, eDone, eAbort}) begin
        errors++;
        $display("[TB] FAIL model cyc=%0d got r=%h g=%h b=%h busy=%b chan=%0d step=%b done=%b abort=%b, expected r=%h g=%h b=%h busy=%b chan=%0d step=%b done=%b abort=%b",
                 cyc, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b, bus.o_cal_busy, bus.o_cal_chan,
                 bus.o_cal_step, bus.o_cal_done, bus.o_cal_abort,
                 eR, eG, eB, eBusy, eChan, eStep, eDone, eAbort);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic hb, input logic vb, input logic te);
    @(negedge clk);
    bus.i_vid_r = r; bus.i_vid_g = g; bus.i_vid_b = b;
    bus.i_hblank = hb; bus.i_vblank = vb; bus.i_test_en = te;
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic linesToRamp();
    for (int i = 0; i < CAL_LINE + 1; i++) begin
      @(negedge clk); bus.i_hblank = 1'b1;
      @(negedge clk); bus.i_hblank = 1'b0;
    end
  endtask

  task automatic waitCode(input string name, input int ch, input logic [7:0] code, input int budget);
    logic [7:0] d;
    bit found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      sample();
      d = (ch == 1) ? bus.o_dac_r : (ch == 2) ? bus.o_dac_g : bus.o_dac_b;
      if (bus.o_cal_step && bus.o_cal_chan == 2'(ch) && d == code) found = 1'b1;
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  int stepCount, doneCount, firstStep, doneCyc, busyCount, nonBlack;

  initial begin
    bus.i_vid_r = 8'h00; bus.i_vid_g = 8'h00; bus.i_vid_b = 8'h00;
    bus.i_hblank = 1'b0; bus.i_vblank = 1'b0; bus.i_test_en = 1'b0;
    rst = 1'b1;
    sample();
    sample();
    checkOutput("reset_dac", {8'h0, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b}, 32'h0);
    checkOutput("reset_status", {bus.o_cal_busy, bus.o_cal_chan, bus.o_cal_step, bus.o_cal_done, bus.o_cal_abort}, 32'h0);

    // Pass-through and blanking
    @(negedge clk); rst = 1'b0;
    bus.i_vid_r = 8'h12; bus.i_vid_g = 8'h34; bus.i_vid_b = 8'h56;
    sample();
    checkOutput("passthrough", {8'h0, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b}, 32'h123456);
    applyStimulus(8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b0);
    sample();
    checkOutput("hblank_black", {8'h0, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b}, 32'h0);

    // Full ramp with hblank toggling underneath
    $display("[TB] full ramp");
    applyStimulus(8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1);
    linesToRamp();
    stepCount = 0; doneCount = 0; firstStep = 0; doneCyc = 0;
    for (int c = 0; c < 2000 && doneCount == 0; c++) begin
      sample();
      if (bus.o_cal_step) begin
        if (stepCount == 0) begin
          firstStep = cyc;
          checkOutput("first_code", {bus.o_cal_chan, bus.o_dac_r}, {2'd1, 8'h00});
        end
        if (stepCount == 300) checkOutput("code_300", {bus.o_cal_chan, bus.o_dac_g}, {2'd2, 8'h2C});
        if (stepCount == 767) checkOutput("code_767", {bus.o_cal_chan, bus.o_dac_b}, {2'd3, 8'hFF});
        stepCount++;
      end
      if (bus.o_cal_done) begin
        doneCount++;
        doneCyc = cyc;
      end
      bus.i_hblank = (c % 5 == 0);
    end
    checkOutput("step_pulses", 32'(stepCount), 32'd768);
    checkOutput("done_pulses", 32'(doneCount), 32'd1);
    checkOutput("done_latency", 32'(doneCyc - firstStep), 32'd1536);
    sample();
    checkOutput("busy_after_done", {31'd0, bus.o_cal_busy}, 32'd0);
    applyStimulus(8'hA5, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);

    // Abort when vblank drops mid green ramp
    $display("[TB] abort");
    applyStimulus(8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b1);
    linesToRamp();
    waitCode("reach_g40", 2, 8'h40, 2000);
    bus.i_vid_r = 8'h9A; bus.i_vid_g = 8'hBC; bus.i_vid_b = 8'hDE; bus.i_vblank = 1'b0;
    sample();
    checkOutput("abort_pulse", {bus.o_cal_abort, bus.o_cal_done, bus.o_cal_busy, bus.o_cal_chan}, {1'b1, 1'b0, 1'b0, 2'd0});
    checkOutput("abort_video", {8'h0, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b}, 32'h9ABCDE);
    sample();
    checkOutput("abort_one_cycle", {31'd0, bus.o_cal_abort}, 32'd0);

    // Disabled across a vblank
    $display("[TB] disabled");
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b0);
    busyCount = 0; nonBlack = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (bus.o_cal_busy) busyCount++;
      if ({bus.o_dac_r, bus.o_dac_g, bus.o_dac_b} != {3{BLACK}}) nonBlack++;
      bus.i_hblank = (c % 3 == 0);
    end
    checkOutput("disabled_busy", 32'(busyCount), 32'd0);
    checkOutput("disabled_black", 32'(nonBlack), 32'd0);

    // Reset mid blue ramp, then a clean restart
    $display("[TB] reset mid-ramp");
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b1);
    linesToRamp();
    waitCode("reach_b80", 3, 8'h80, 3000);
    rst = 1'b1;
    sample();
    checkOutput("rst_dac", {8'h0, bus.o_dac_r, bus.o_dac_g, bus.o_dac_b}, 32'h0);
    checkOutput("rst_status", {bus.o_cal_busy, bus.o_cal_abort, bus.o_cal_chan}, 32'h0);
    rst = 1'b0; bus.i_vblank = 1'b0;
    sample();
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b1);
    linesToRamp();
    waitCode("restart_r0", 1, 8'h00, 20);
    applyStimulus(8'h77, 8'h88, 8'h99, 1'b0, 1'b0, 1'b1);

    // Late enable inside vblank, then start on the next vblank edge
    $display("[TB] late enable");
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1);
    busyCount = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (bus.o_cal_busy) busyCount++;
      bus.i_hblank = (c % 2 == 0);
    end
    checkOutput("late_enable_idle", 32'(busyCount), 32'd0);
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1);
    sample();
    sample();
    checkOutput("next_vblank_busy", {31'd0, bus.o_cal_busy}, 32'd1);
    linesToRamp();
    waitCode("late_start_r0", 1, 8'h00, 20);
    applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1);
    repeat (4) sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
